collision_event_scheduler: RTL

Turns the per-pixel collision flags from the game controller into discrete, once-per-frame game events and delivers them one at a time, in fixed priority, over a valid/ready handshake to the game-state logic (score, lives, shot and enemy managers). Collisions are accumulated for the whole frame, committed at `startOfFrame`, and drained one event per clock. Frame-to-frame merging and loss are flagged.

---
 rtl/collision_event_scheduler.sv | 137 +++++++++++++
 1 files changed

// File: rtl/collision_event_scheduler.sv
// Collects per-frame collision flags, commits them at start of frame and
// delivers them one per clock, highest priority first, over valid/ready.
module collision_event_scheduler #(
  parameter int NUM_SHOTS = 3
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 towerPlayerCollision,
  input  logic                 TowerEnemyHUCollision,
  input  logic [NUM_SHOTS-1:0] ShotEnemyCollision,
  input  logic [NUM_SHOTS-1:0] ShotHeadsDownCollision,
  input  logic [NUM_SHOTS-1:0] ShotBoxCollision,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [2:0]           event_type,
  output logic [1:0]           event_shot,
  output logic                 frame_done,
  output logic                 merge_overflow
);

  localparam int NV = 2 + 3 * NUM_SHOTS;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t          state_reg, state_next;
  logic [NV-1:0]   in_vec, snap;
  logic [NV-1:0]   sticky_reg, sticky_next;
  logic [NV-1:0]   pending_reg, pending_next;
  logic [NV-1:0]   pick_onehot, issued_bit, pending_kept;
  logic [2:0]      type_reg, type_next, pick_type;
  logic [1:0]      shot_reg, shot_next, pick_shot;
  logic            frame_done_reg, frame_done_next;
  logic            merge_reg, merge_next;
  logic            load;
  logic [2:0]      bit_type [NV];
  logic [1:0]      bit_shot [NV];

  // Bit 0 is the highest priority; shot groups follow in priority order.
  assign in_vec = {ShotBoxCollision, ShotHeadsDownCollision, ShotEnemyCollision,
                   TowerEnemyHUCollision, towerPlayerCollision};

  genvar gi;
  generate
    for (gi = 0; gi < NV; gi++) begin : g_map
      if (gi < 2) begin : g_tower
        assign bit_type[gi] = 3'(gi + 1);
        assign bit_shot[gi] = 2'd3;
      end else begin : g_shot
        assign bit_type[gi] = 3'(3 + (gi - 2) / NUM_SHOTS);
        assign bit_shot[gi] = 2'((gi - 2) % NUM_SHOTS);
      end
    end
  endgenerate

  // Lowest set bit of the pre-commit pending vector.
  assign pick_onehot = pending_reg & (~pending_reg + NV'(1));

  always_comb begin
    pick_type = '0;
    pick_shot = '0;
    for (int i = 0; i < NV; i++) begin
      if (pick_onehot[i]) begin
        pick_type = pick_type | bit_type[i];
        pick_shot = pick_shot | bit_shot[i];
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    type_next       = type_reg;
    shot_next       = shot_reg;
    frame_done_next = 1'b0;
    load            = 1'b0;
    snap            = sticky_reg | in_vec;

    case (state_reg)
      IDLE: begin
        if (pending_reg != '0) load = 1'b1;
      end
      OFFER: begin
        if (event_ready) begin
          if (pending_reg != '0) begin
            load = 1'b1;
          end else begin
            state_next      = IDLE;
            type_next       = 3'd0;
            shot_next       = 2'd3;
            // A commit refilling pending means the drain is not finished.
            frame_done_next = !(startOfFrame && (snap != '0));
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      state_next = OFFER;
      type_next  = pick_type;
      shot_next  = pick_shot;
    end

    issued_bit   = load ? pick_onehot : '0;
    pending_kept = pending_reg & ~issued_bit;
    pending_next = startOfFrame ? (pending_kept | snap) : pending_kept;
    merge_next   = startOfFrame && ((pending_kept & snap) != '0);
    sticky_next  = startOfFrame ? '0 : snap;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg      <= IDLE;
      sticky_reg     <= '0;
      pending_reg    <= '0;
      type_reg       <= 3'd0;
      shot_reg       <= 2'd3;
      frame_done_reg <= 1'b0;
      merge_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sticky_reg     <= sticky_next;
      pending_reg    <= pending_next;
      type_reg       <= type_next;
      shot_reg       <= shot_next;
      frame_done_reg <= frame_done_next;
      merge_reg      <= merge_next;
    end
  end

  assign event_valid    = (state_reg == OFFER);
  assign event_type     = type_reg;
  assign event_shot     = shot_reg;
  assign frame_done     = frame_done_reg;
  assign merge_overflow = merge_reg;

endmodule
